// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch block
package cpu_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of {pc, inst} entries with flush
module fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         enq,
  input  logic                         deq,
  input  fetch_entry_t                 enq_data,
  output logic                         full,
  output logic                         empty,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_enq;
  logic            do_deq;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign do_deq = deq && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_enq = enq && (!full || do_deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_enq) - CW'(do_deq);
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer: pc, fetch FSM and decode queue
module inst_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fetch_cnt
);

  fetch_state_t                state;
  logic [ADDR_W-1:0]           pc;
  logic                        q_full;
  logic                        q_empty;
  fetch_entry_t                q_head;
  logic [$clog2(QDEPTH+1)-1:0] q_count;
  logic                        deq;
  logic                        fetch;
  logic                        misaligned;

  assign rom_addr   = pc;
  assign out_valid  = !q_empty;
  assign out_inst   = q_head.inst;
  assign out_pc     = q_head.pc;
  assign halted     = (state == ST_HALTED) && (q_count == '0);
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // Redirect wins over both ends of the queue.
  assign deq        = out_valid && out_ready && !redirect_valid;
  assign fetch      = (state == ST_RUN) && !redirect_valid && !halt_req && (!q_full || deq);

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .enq      (fetch),
    .deq      (deq),
    .enq_data ('{pc: pc, inst: rom_inst}),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head),
    .count    (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else if (misaligned) begin
      state <= ST_FAULT;
      fault <= 1'b1;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (state == ST_RUN && halt_req) state <= ST_HALTED;
    end else begin
      if (fetch) begin
        pc        <= pc + PC_STEP;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      case (state)
        ST_IDLE:   if (start) state <= ST_RUN;
        ST_RUN:    if (halt_req) state <= ST_HALTED;
        ST_HALTED: if (start) state <= ST_RUN;
        default:   state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard bench for inst_fetch_ctrl with a queue-level reference model
module tb_inst_fetch_ctrl;

  localparam int QD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, redirect_valid, out_ready;
  logic [31:0] redirect_pc, rom_addr, rom_inst, out_inst, out_pc, fetch_cnt;
  logic        out_valid, halted, fault;

  always #5 clk = ~clk;

  assign rom_inst = {16'hA5A5, rom_addr[15:0]};

  inst_fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(QD), .PC_STEP(32'd4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          mst;
  logic [31:0] mpc, mcnt;
  logic        mfault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    return 32'hA5A5_0000 | (a & 32'h0000_FFFF);
  endfunction

  task automatic model_reset();
    sb.delete();
    mst    = M_IDLE;
    mpc    = 32'h0;
    mcnt   = 32'h0;
    mfault = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs held during the cycle.
  task automatic model_edge();
    if (!rst_n) return;
    if (redirect_valid) begin
      sb.delete();
      if (redirect_pc[1:0] != 2'b00) begin
        mst    = M_FAULT;
        mfault = 1'b1;
      end else begin
        mpc = redirect_pc;
        if (mst == M_RUN && halt_req) mst = M_HALT;
      end
    end else begin
      if (mst == M_RUN && !halt_req && sb.size() < QD) begin
        sb.push_back('{pc: mpc, inst: rom_model(mpc)});
        mpc  = mpc + 32'd4;
        mcnt = mcnt + 32'd1;
      end
      if      (mst == M_IDLE && start)    mst = M_RUN;
      else if (mst == M_RUN  && halt_req) mst = M_HALT;
      else if (mst == M_HALT && start)    mst = M_RUN;
    end
  endtask

  task automatic cyc(input logic st, input logic hr, input logic rv,
                     input logic [31:0] rp, input logic rdy);
    @(posedge clk);
    model_edge();
    #1;
    start          = st;
    halt_req       = hr;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #1;
    rst_n          = 1'b0;
    start          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_inst", out_inst, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the model and retires accepted heads.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
      chk("rom_addr", rom_addr, mpc);
      chk("fetch_cnt", fetch_cnt, mcnt);
      chk("fault", {31'b0, fault}, {31'b0, mfault});
      chk("halted", {31'b0, halted}, {31'b0, (mst == M_HALT) && (sb.size() == 0)});
      if (sb.size() != 0) begin
        chk("out_pc", out_pc, sb[0].pc);
        chk("out_inst", out_inst, sb[0].inst);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;
    model_reset();
    do_reset();

    // sequential fetch with decode always ready
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

    // backpressure fills the queue, then release
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

    // redirect to 0x40 while older entries are queued
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h40, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

    // halt, drain, resume
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

    // wrap of the pc past the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      if ($urandom_range(0, 99) < 1) begin
        do_reset();
      end else begin
        rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                         : 32'($urandom_range(0, 1023) * 4);
        cyc($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 4, rp, $urandom_range(0, 99) < 65);
      end
    end

    // misaligned redirect: permanent fault until reset
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h42, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    do_reset();
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction-fetch sequencer for the simple CPU. Owns the program counter and drives the address of the combinational instruction ROM (byte address, 32-bit word per fetch). Buffers fetched {pc, inst} pairs in a small queue that feeds decode over a valid/ready handshake. Handles start, halt, branch/jump redirect with flush, and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; must be 4-byte aligned.
QDEPTH, 2, fetch queue entries; legal values are 2 or 4.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  in  1  Single clock; all state updates on the rising edge.
rst_n  in  1  Reset, asynchronous, active-low. Forces every register to its reset value.
start  in  1  Single-cycle pulse; begins or resumes fetching from IDLE or HALTED.
halt_req  in  1  Stops new fetches; the queue keeps draining.
redirect_valid  in  1  Branch or jump taken this cycle.
redirect_pc  in  32  Target byte address.
rom_addr  out  32  Address to the instruction ROM; equals pc combinationally.
rom_inst  in  32  ROM data; valid in the same cycle as rom_addr.
out_valid  out  1  Queue head valid.
out_ready  in  1  Decode accepts the head.
out_inst  out  32  Head instruction.
out_pc  out  32  Address of the head instruction.
halted  out  1  High when state is HALTED and the queue is empty.
fault  out  1  Sticky flag; misaligned redirect target.
fetch_cnt  out  32  Number of instructions enqueued since reset; wraps modulo 2^32.

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, queue empty.
  - out_valid=0, out_inst=0, out_pc=0.
  - halted=0, fault=0, fetch_cnt=0.
- States:
  - IDLE: start moves to RUN.
  - RUN: halt_req moves to HALTED.
  - HALTED: start moves to RUN.
  - Any state: redirect_valid with redirect_pc[1:0]!=0 moves to FAULT.
  - FAULT: exits only through reset.
- start is ignored in RUN and FAULT.
- Fetch condition, evaluated each cycle:
  - Requires state==RUN, no redirect this cycle, and halt_req==0.
  - Also requires the queue not full, or the queue full with a dequeue in the same cycle.
  - On fetch, {pc, rom_inst} is enqueued at the clock edge, pc <= pc+PC_STEP (wraps 32'hFFFF_FFFC -> 0), and fetch_cnt increments.
- Dequeue occurs when out_valid && out_ready. Data is registered, so the head is stable while out_ready=0.
- Latency:
  - start sampled at edge E0 moves the state to RUN.
  - RESET_PC is fetched during the following cycle; out_valid rises after E1.
  - Sustained throughput is 1 instruction per cycle while out_ready=1.
- Redirect, aligned target:
  - Has priority over fetch and dequeue.
  - Queue is flushed, so out_valid=0 after the edge.
  - pc <= redirect_pc; no enqueue in that cycle.
  - The state is unchanged, except that halt_req in the same cycle still moves RUN to HALTED.
  - In IDLE or HALTED the redirect only updates pc and flushes the queue.
- Redirect, misaligned target: pc is unchanged, the queue is flushed, fault=1, state=FAULT. No further fetches; out_valid stays 0.
- Simultaneous enqueue and dequeue when the queue is full: allowed; the count is unchanged.
- Queue empty with out_ready=1: no effect.
- Reset asserted mid-operation: immediate return to the reset values; any queued entries are lost.

Decomposition:
- Package cpu_fetch_pkg holds:
  - the state encoding (IDLE, RUN, HALTED, FAULT), 2-bit;
  - INST_W=32 and ADDR_W=32;
  - the default RESET_PC.
- Sub-module fetch_queue: a parameterised synchronous FIFO with a flush input.
  - Inputs: flush, enq, deq.
  - Outputs: full, empty, head, count.
  - Storage: {pc, inst}, QDEPTH entries.
- The controller contains the FSM, the pc register and the counter.

Test Plan:
All scenarios use a bench ROM model returning rom_inst = {16'hA5A5, addr[15:0]}.
1. Reset, start pulse, out_ready=1 -> out_valid rises 2 cycles after start; out_pc sequence 0,4,8,12 with out_inst 32'hA5A5_0000, A5A5_0004, A5A5_0008, A5A5_000C; fetch_cnt=4 after 4 fetches.
2. RUN with out_ready=0 for 5 cycles -> queue fills at QDEPTH=2 entries (pc 0,4); rom_addr holds 8; head stays out_pc=0; releasing out_ready resumes at 8 with no loss or duplication.
3. Redirect to 32'h40 while the queue holds pc 4 and 8 -> next cycle out_valid=0; following outputs are out_pc 0x40 then 0x44, out_inst 32'hA5A5_0040; pc 4 and 8 never reach decode.
4. halt_req in RUN -> fetching stops; queued entries drain; halted=1 once the queue is empty; start resumes at the saved pc.
5. Redirect to 32'h42 -> fault=1, state FAULT, out_valid=0 permanently; start is ignored; rst_n low clears fault and restores pc=0.
6. Redirect to 32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
